ram_sync_param: RTL and testbench
=================================

# ram_sync_param

Parametrised single-port synchronous RAM: the successor to the fixed 4x16 flip-flop RAM. Depth and word width are generics. Reads are registered, and a one-cycle `valid` strobe marks each read result. A built-in scrub engine walks every address after `clear` (fill with `INIT_VAL`) or `preset` (fill with all-ones), and holds `busy` while it runs. It sits between the datapath register logic and any block that needs a small addressable store with a known post-reset content.

## Interface
- `ADDR_W`, default 2: address width; DEPTH = 2^ADDR_W words.
- `DATA_W`, default 16: word width in bits.
- `INIT_VAL`, default 0: word value written by a `clear` scrub; DATA_W bits wide.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `clear`  in  1  reset, synchronous and active-high; starts an INIT_VAL scrub.
- `preset`  in  1  synchronous active-high; starts an all-ones scrub.
- `en`  in  1  access request, sampled at the rising edge.
- `r_w`  in  1  1 = write, 0 = read; qualified by `en`.
- `addr`  in  ADDR_W  word address.
- `in`  in  DATA_W  write data.
- `out`  out  DATA_W  registered read data; holds its value between reads.
- `valid`  out  1  one-cycle pulse when `out` carries new read data.
- `busy`  out  1  scrub in progress; all accesses are ignored while high.

## Operation
- States: IDLE and SCRUB. Internal registers: scrub pointer `ptr` (ADDR_W bits) and fill word `fill` (DATA_W bits).
- `clear` high at an edge:
  - state <= SCRUB, ptr <= 0, fill <= INIT_VAL.
  - busy <= 1, valid <= 0, out <= 0.
  - Takes priority over `preset` and over any access.
- `preset` high at an edge with `clear` low:
  - state <= SCRUB, ptr <= 0, fill <= all-ones.
  - busy <= 1, valid <= 0; `out` is unchanged.
  - If a scrub is already running, it restarts from 0 with the new fill word.
- SCRUB, with `clear` and `preset` both low:
  - Each edge writes mem[ptr] <= fill and increments ptr.
  - The edge that writes ptr = DEPTH-1 also sets state <= IDLE and busy <= 0. ptr wraps to 0.
  - While `clear` or `preset` is held high, ptr stays at 0 and no scrub write occurs.
- IDLE:
  - `en & r_w`: mem[addr] <= in; valid <= 0; `out` holds.
  - `en & ~r_w`: out <= mem[addr]; valid <= 1.
  - `~en`: valid <= 0; `out` holds.
- Any `en` while busy = 1 is dropped silently: no write, no valid. The requester must wait for `busy` = 0.
- Words that are never written after a scrub read back as the fill value.

## Timing
- Reset values, after an edge with `clear` = 1: out = 0, valid = 0, busy = 1, state = SCRUB, ptr = 0.
- Scrub duration is exactly DEPTH cycles after the scrub request is released:
  - Request low at edges E1..E_DEPTH; word k is written at edge E(k+1).
  - busy reads 0 after edge E_DEPTH. With ADDR_W = 2, busy falls 4 cycles after `clear` drops.
- Read latency is 1 cycle: request sampled at edge N; out and valid update at edge N; valid falls at edge N+1 unless another read is issued.
- Back-to-back reads produce one valid cycle each, with consecutive data.
- Write then read of the same address on the next cycle returns the new data. There is no bypass hazard because accesses are single-port and the write completes at its own edge.
- The first access accepted after a scrub is the one sampled at the edge after busy reads 0.
- A `clear` mid-scrub or mid-read takes effect at that edge: the pending valid is suppressed and the scrub restarts at 0.

## Test plan
1. Defaults. Assert clear for 2 cycles and release, then read addresses 0..3. Required: busy stays high 4 cycles after release; each read returns 0x0000 with valid = 1 for one cycle.
2. Write/readback. Write 63, 1023, 4095, 65535 to addresses 0..3, then read 0..3 back-to-back. Required: out = 0x003F, 0x03FF, 0x0FFF, 0xFFFF on consecutive cycles, with valid high for 4 cycles.
3. Preset fill. After test 2, write 0x1234 to address 1, pulse preset, wait for busy low, then read address 1. Required: out = 0xFFFF; out stays at its pre-preset value during the scrub.
4. Access during busy. Issue a write of 0xAAAA to address 2 during a clear scrub, then read address 2 after busy falls. Required: out = 0x0000, and valid never pulses while busy = 1.
5. Priority and restart. Assert clear and preset together; separately, pulse preset at scrub cycle 2 of a clear scrub. Required: the simultaneous case fills with INIT_VAL; the restart case gives busy 4 more cycles and all words read 0xFFFF.
6. Generics. Use ADDR_W = 4, DATA_W = 8, INIT_VAL = 0x5A. Clear, then write 0xC3 to address 15 and read addresses 15 and 0. Required: busy lasts 16 cycles; reads return 0xC3 and 0x5A.

Source files
------------

// File: rtl/ram_sync_param.sv
// ram_sync_param: single-port synchronous RAM with registered reads and a clear/preset scrub engine
module ram_sync_param #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              preset,
  input  logic              en,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              valid,
  output logic              busy
);
  typedef enum logic {IDLE, SCRUB} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, wa;
  logic [DATA_W-1:0] fill_q, fill_d, out_q, out_d, wd;
  logic valid_q, valid_d, we;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    fill_d = fill_q;
    out_d = out_q;
    valid_d = 1'b0;
    we = 1'b0;
    wa = addr;
    wd = in;
    if (clear || preset) begin
      state_d = SCRUB;
      ptr_d = '0;
      fill_d = clear ? INIT_VAL : '1;
      out_d = clear ? '0 : out_q;
    end else if (state_q == SCRUB) begin
      we = 1'b1;
      wa = ptr_q;
      wd = fill_q;
      ptr_d = ptr_q + 1'b1;
      state_d = (ptr_q == '1) ? IDLE : SCRUB;
    end else if (en) begin
      we = r_w;
      valid_d = ~r_w;
      out_d = r_w ? out_q : mem_q[addr];
    end
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    ptr_q <= ptr_d;
    fill_q <= fill_d;
    out_q <= out_d;
    valid_q <= valid_d;
  end
  always_ff @(posedge clk) if (we) mem_q[wa] <= wd;
  assign out = out_q;
  assign valid = valid_q;
  assign busy = (state_q == SCRUB);
endmodule

// File: tb/tb_ram_sync_param.sv
// tb_ram_sync_param: directed self-checking bench for ram_sync_param (default and 16x8 configurations)
module tb_ram_sync_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clear = 1'b0, preset = 1'b0, en = 1'b0, r_w = 1'b0;
  logic [1:0] addr = '0;
  logic [15:0] in = '0, out;
  logic valid, busy;
  logic b_clear = 1'b0, b_en = 1'b0, b_r_w = 1'b0;
  logic [3:0] b_addr = '0;
  logic [7:0] b_in = '0, b_out;
  logic b_valid, b_busy;
  int checks = 0, errors = 0;
  ram_sync_param dut (
    .clk(clk), .clear(clear), .preset(preset), .en(en), .r_w(r_w),
    .addr(addr), .in(in), .out(out), .valid(valid), .busy(busy)
  );
  ram_sync_param #(.ADDR_W(4), .DATA_W(8), .INIT_VAL(8'h5A)) dut_b (
    .clk(clk), .clear(b_clear), .preset(1'b0), .en(b_en), .r_w(b_r_w),
    .addr(b_addr), .in(b_in), .out(b_out), .valid(b_valid), .busy(b_busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
    en = 1'b1; r_w = 1'b0; addr = a;
    tick();
    check({tag, "_out"}, out, exp);
    check({tag, "_valid"}, valid, 1);
  endtask
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    en = 1'b1; r_w = 1'b1; addr = a; in = d;
    tick();
    check("wr_valid", valid, 0);
  endtask
  task automatic idle_chk();
    en = 1'b0;
    tick();
    check("idle_valid", valid, 0);
  endtask
  task automatic scrub_wait(input string tag);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check(tag, busy, i < 4);
    end
  endtask
  logic [15:0] wvals [4] = '{16'h003F, 16'h03FF, 16'h0FFF, 16'hFFFF};
  initial begin
    // test 1: reset defaults
    clear = 1'b1;
    tick();
    check("rst_out", out, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 1);
    tick();
    clear = 1'b0;
    scrub_wait("t1_busy");
    for (int i = 0; i < 4; i++) rd(2'(i), 16'h0000, "t1_rd");
    idle_chk();
    // test 2: write/readback
    for (int i = 0; i < 4; i++) wr(2'(i), wvals[i]);
    for (int i = 0; i < 4; i++) rd(2'(i), wvals[i], "t2_rd");
    idle_chk();
    // test 3: preset fill, out holds during scrub
    wr(2'd1, 16'h1234);
    rd(2'd1, 16'h1234, "t3_pre");
    rd(2'd0, 16'h003F, "t3_last");
    en = 1'b0; preset = 1'b1;
    tick();
    preset = 1'b0;
    check("t3_busy0", busy, 1);
    check("t3_hold0", out, 16'h003F);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t3_busy", busy, i < 4);
      check("t3_hold", out, 16'h003F);
      check("t3_valid", valid, 0);
    end
    rd(2'd1, 16'hFFFF, "t3_rd1");
    rd(2'd2, 16'hFFFF, "t3_rd2");
    // test 4: accesses during a clear scrub are dropped
    en = 1'b1; r_w = 1'b0; addr = 2'd3; clear = 1'b1;
    tick();
    check("t4_clr_valid", valid, 0);
    check("t4_clr_out", out, 0);
    clear = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t4_busy_valid", valid, 0);
      check("t4_busy", busy, 1);
    end
    r_w = 1'b1; addr = 2'd2; in = 16'hAAAA;
    tick();
    check("t4_busy_end", busy, 0);
    check("t4_valid_end", valid, 0);
    rd(2'd2, 16'h0000, "t4_rd2");
    // test 5a: clear beats preset
    for (int i = 0; i < 4; i++) wr(2'(i), 16'h5555);
    en = 1'b0; clear = 1'b1; preset = 1'b1;
    tick();
    clear = 1'b0; preset = 1'b0;
    scrub_wait("t5a_busy");
    for (int i = 0; i < 4; i++) rd(2'(i), 16'h0000, "t5a_rd");
    // test 5b: preset restarts a running clear scrub
    en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
    preset = 1'b1;
    tick();
    preset = 1'b0;
    scrub_wait("t5b_busy");
    for (int i = 0; i < 4; i++) rd(2'(i), 16'hFFFF, "t5b_rd");
    idle_chk();
    // test 6: 16x8 configuration
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i >= 15) check("t6_busy", b_busy, i < 16);
    end
    b_en = 1'b1; b_r_w = 1'b1; b_addr = 4'd15; b_in = 8'hC3;
    tick();
    b_r_w = 1'b0;
    tick();
    check("t6_rd15", b_out, 8'hC3);
    check("t6_v15", b_valid, 1);
    b_addr = 4'd0;
    tick();
    check("t6_rd0", b_out, 8'h5A);
    b_en = 1'b0;
    tick();
    check("t6_vend", b_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
